bram_arbiter: RTL
=================

// Module: bram_arbiter
// PURPOSE
//  Shares one BRAMIfc server (write/read/dataOut) between two clients. Registered turn token grants
//  one client per cycle, alternating. Reads are tracked one at a time; returning data is steered
//  into a per-client response register the owning client drains. Sits between the BRAM and its two users.
// PARAMETERS
//  DEPTH  1024  BRAM word count; AW = $clog2(DEPTH)
//  WIDTH  48    BRAM data width
// PORTS (cN = c0, c1; identical sets)
//  CLK                 in   1      clock
//  RST                 in   1      synchronous reset, active-high
//  cN_write__ENA       in   1      client write fire (only while cN_write__RDY)
//  cN_write$addr       in   AW     write address
//  cN_write$data       in   WIDTH  write data
//  cN_write__RDY       out  1      write may fire this cycle
//  cN_read__ENA        in   1      client read fire (only while cN_read__RDY)
//  cN_read$addr        in   AW     read address
//  cN_read__RDY        out  1      read may fire this cycle
//  cN_dataOut          out  WIDTH  held read response
//  cN_dataOut__RDY     out  1      response valid
//  cN_deq__ENA         in   1      client consumes response (only while cN_dataOut__RDY)
//  bram.* (client modport)         write__ENA/addr/data, read__ENA/addr out; write__RDY, read__RDY, dataOut, dataOut__RDY in
// BEHAVIOUR
//  Clock CLK; reset synchronous, active-high (RST).
//  State: st {IDLE, RD_WAIT}, turn (1b), rd_owner (1b), rspV[1:0], rspD[1:0][WIDTH].
//  Reset: st=IDLE, turn=0, rd_owner=0, rspV=0, rspD=0; all cN_*__RDY and bram.*__ENA low the cycle after.
//  RDY never depends on any ENA (no comb loops):
//   cN_write__RDY = st==IDLE && turn==N && bram.write__RDY
//   cN_read__RDY  = st==IDLE && turn==N && bram.read__RDY && !rspV[N]
//  Client must not assert write__ENA and read__ENA together; if it does, write wins, read dropped.
//  Pass-through: bram.write__ENA = OR of granted cN_write__ENA, addr/data muxed by turn; same for read.
//  Turn: flips every IDLE cycle (fire or not) -> each client gets a slot at least every 2nd IDLE cycle.
//   Turn holds while in RD_WAIT; the flip occurring on the read-fire cycle still applies.
//  Write: 1 cycle, st stays IDLE.
//  Read fire (cN_read__ENA in IDLE): rd_owner<=N, st<=RD_WAIT next cycle.
//  RD_WAIT: all cN RDYs low. On bram.dataOut__RDY: rspD[rd_owner]<=bram.dataOut, rspV[rd_owner]<=1,
//   st<=IDLE. Latency: response visible at client >=2 cycles after read fire (BRAM 1-cycle -> exactly 2).
//  cN_dataOut=rspD[N], cN_dataOut__RDY=rspV[N]. cN_deq__ENA clears rspV[N] next cycle; rspD holds value.
//  Same-cycle deq and new fill for one client cannot occur (read__RDY gated by !rspV).
//  A client with undrained response may still write; other client unaffected.
//  bram.dataOut__RDY while IDLE: ignored (no fill).
//  RST mid RD_WAIT: st=IDLE, pending read discarded, rspV cleared; late BRAM data ignored.
//  bram.write__RDY/read__RDY low: corresponding client RDYs low; turn still flips.
// TESTING
//  1. Reset, c0 write addr 5 data 0xABC at turn=0 -> bram.write__ENA 1 cycle, addr 5, data 0xABC; turn=1 next.
//  2. Both clients writing continuously 8 cycles -> grants alternate c0,c1,c0..., 4 writes each, no overlap.
//  3. c1 read addr 5 -> 2 cycles later c1_dataOut__RDY=1, c1_dataOut=0xABC; c0 RDYs low during RD_WAIT.
//  4. c0 response left undrained, c0 reads again -> c0_read__RDY stays 0; c0 write still granted; deq reopens read.
//  5. Read fired then RST on RD_WAIT cycle -> st IDLE, rspV=0, turn=0; subsequent dataOut__RDY produces no response.
//  6. Hold bram.read__RDY=0 -> no cN_read__RDY for 10 cycles, writes continue alternating normally.

Source files
------------

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-client arbiter in front of a single BRAM server
// Alternating turn token grants one client per cycle; one read in flight, response parked per client.
module bram_arbiter #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 48,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic             c0_write__ENA,
  input  logic [AW-1:0]    c0_write_addr,
  input  logic [WIDTH-1:0] c0_write_data,
  output logic             c0_write__RDY,
  input  logic             c0_read__ENA,
  input  logic [AW-1:0]    c0_read_addr,
  output logic             c0_read__RDY,
  output logic [WIDTH-1:0] c0_dataOut,
  output logic             c0_dataOut__RDY,
  input  logic             c0_deq__ENA,

  input  logic             c1_write__ENA,
  input  logic [AW-1:0]    c1_write_addr,
  input  logic [WIDTH-1:0] c1_write_data,
  output logic             c1_write__RDY,
  input  logic             c1_read__ENA,
  input  logic [AW-1:0]    c1_read_addr,
  output logic             c1_read__RDY,
  output logic [WIDTH-1:0] c1_dataOut,
  output logic             c1_dataOut__RDY,
  input  logic             c1_deq__ENA,

  output logic             bram_write__ENA,
  output logic [AW-1:0]    bram_write_addr,
  output logic [WIDTH-1:0] bram_write_data,
  input  logic             bram_write__RDY,
  output logic             bram_read__ENA,
  output logic [AW-1:0]    bram_read_addr,
  input  logic             bram_read__RDY,
  input  logic [WIDTH-1:0] bram_dataOut,
  input  logic             bram_dataOut__RDY
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_WAIT = 1'b1;

  logic [0:0]       st_q, st_d;
  logic             turn_q, turn_d;
  logic             rd_owner_q, rd_owner_d;
  logic [1:0]       rsp_v_q, rsp_v_d;
  logic [WIDTH-1:0] rsp_d0_q, rsp_d0_d;
  logic [WIDTH-1:0] rsp_d1_q, rsp_d1_d;

  logic slot_open;
  logic c0_wfire, c1_wfire;
  logic c0_rfire, c1_rfire;
  logic rd_fire;

  // Grants are pure functions of state and BRAM readiness, never of a client ENA.
  assign slot_open     = !RST && (st_q == ST_IDLE);
  assign c0_write__RDY = slot_open && !turn_q && bram_write__RDY;
  assign c1_write__RDY = slot_open &&  turn_q && bram_write__RDY;
  assign c0_read__RDY  = slot_open && !turn_q && bram_read__RDY && !rsp_v_q[0];
  assign c1_read__RDY  = slot_open &&  turn_q && bram_read__RDY && !rsp_v_q[1];

  // A write and a read from the same client in one cycle: the write is kept.
  assign c0_wfire = c0_write__ENA && c0_write__RDY;
  assign c1_wfire = c1_write__ENA && c1_write__RDY;
  assign c0_rfire = c0_read__ENA && c0_read__RDY && !c0_write__ENA;
  assign c1_rfire = c1_read__ENA && c1_read__RDY && !c1_write__ENA;
  assign rd_fire  = c0_rfire || c1_rfire;

  assign bram_write__ENA = c0_wfire || c1_wfire;
  assign bram_write_addr = turn_q ? c1_write_addr : c0_write_addr;
  assign bram_write_data = turn_q ? c1_write_data : c0_write_data;
  assign bram_read__ENA  = rd_fire;
  assign bram_read_addr  = turn_q ? c1_read_addr : c0_read_addr;

  assign c0_dataOut      = rsp_d0_q;
  assign c1_dataOut      = rsp_d1_q;
  assign c0_dataOut__RDY = rsp_v_q[0];
  assign c1_dataOut__RDY = rsp_v_q[1];

  always_comb begin
    st_d       = st_q;
    turn_d     = turn_q;
    rd_owner_d = rd_owner_q;
    rsp_v_d    = rsp_v_q;
    rsp_d0_d   = rsp_d0_q;
    rsp_d1_d   = rsp_d1_q;

    if (c0_deq__ENA) rsp_v_d[0] = 1'b0;
    if (c1_deq__ENA) rsp_v_d[1] = 1'b0;

    case (st_q)
      ST_IDLE: begin
        turn_d = !turn_q;
        if (rd_fire) begin
          rd_owner_d = turn_q;
          st_d       = ST_RD_WAIT;
        end
      end
      default: begin
        // Turn is frozen here; data returning while idle is never captured.
        if (bram_dataOut__RDY) begin
          st_d = ST_IDLE;
          if (rd_owner_q) begin
            rsp_d1_d   = bram_dataOut;
            rsp_v_d[1] = 1'b1;
          end else begin
            rsp_d0_d   = bram_dataOut;
            rsp_v_d[0] = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q       <= ST_IDLE;
      turn_q     <= 1'b0;
      rd_owner_q <= 1'b0;
      rsp_v_q    <= 2'b00;
      rsp_d0_q   <= '0;
      rsp_d1_q   <= '0;
    end else begin
      st_q       <= st_d;
      turn_q     <= turn_d;
      rd_owner_q <= rd_owner_d;
      rsp_v_q    <= rsp_v_d;
      rsp_d0_q   <= rsp_d0_d;
      rsp_d1_q   <= rsp_d1_d;
    end
  end

endmodule
